mem_arbiter: RTL and testbench

Two-master arbiter and sequencer placed directly upstream of the single-port data memory. It accepts word fetches from the instruction-fetch stage and byte/word loads and stores from the load-store stage, with level req/ack handshakes. It arbitrates round-robin and drives the memory's `en`/`write_enable`/`byte_enable`/`byte_select`/`addr`/`data_in` port. For reads it captures the memory's registered `data_out` one cycle after issue and returns it to the granted master.

---
 rtl/d16_mem_pkg.sv | 19 +
 rtl/rr_arb2.sv | 24 ++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/d16_mem_pkg.sv
// Shared definitions for the data-memory arbiter: widths, FSM encoding and
// grant identifiers.
package d16_mem_pkg;

  localparam int unsigned AddrWidth = 16;
  localparam int unsigned DataWidth = 16;

  // Grant identifiers; also the encoding stored in last_grant.
  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StResp  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick: a lone requester always wins, a tie goes to
// whichever master was not granted last.
module rr_arb2
  import d16_mem_pkg::*;
(
  input  logic f_req,
  input  logic d_req,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt
);

  // Pick the winner from the current request pair.
  always_comb begin
    gnt_valid = f_req | d_req;
    gnt       = GNT_FETCH;
    if (f_req && d_req) begin
      gnt = (last_grant == GNT_DATA) ? GNT_FETCH : GNT_DATA;
    end else if (d_req) begin
      gnt = GNT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and load/store accesses onto the single-port
// data memory, sequencing each access as issue / response / ack.
module mem_arbiter
  import d16_mem_pkg::*;
#(
  parameter int unsigned AW = AddrWidth,
  parameter int unsigned DW = DataWidth
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_byte,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic          mem_byte_enable,
  output logic          mem_byte_select,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_data_out,
  input  logic          mem_wait
);

  arb_state_e    state_q, state_d;
  logic          gnt_valid, gnt;
  logic          gnt_q;
  logic          last_grant_q;
  logic          we_q, be_q, bs_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          grant_now;

  // Fetches are word reads, so the low address bit carries no information.
  logic unused_f_addr0;
  assign unused_f_addr0 = f_addr[0];

  rr_arb2 u_rr_arb2 (
    .f_req      (f_req),
    .d_req      (d_req),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // Requests are only looked at while idle; DONE deliberately ignores them.
  assign grant_now = (state_q == StIdle) && gnt_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_valid) state_d = StIssue;
      StIssue: if (!mem_wait) state_d = we_q ? StDone : StResp;
      StResp:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Command latch, response register and round-robin history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q        <= GNT_FETCH;
      last_grant_q <= GNT_DATA;
      we_q         <= 1'b0;
      be_q         <= 1'b0;
      bs_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      if (grant_now) begin
        gnt_q <= gnt;
        if (gnt == GNT_FETCH) begin
          we_q   <= 1'b0;
          be_q   <= 1'b0;
          bs_q   <= 1'b0;
          addr_q <= {1'b0, f_addr[AW-1:1]};
        end else begin
          we_q    <= d_we;
          be_q    <= d_byte;
          bs_q    <= d_byte & d_addr[0];
          addr_q  <= {1'b0, d_addr[AW-1:1]};
          wdata_q <= d_wdata;
        end
      end
      // Memory output is registered, so it is valid in the cycle after acceptance.
      if (state_q == StResp) begin
        rdata_q <= mem_data_out;
      end
      if (state_q == StDone) begin
        last_grant_q <= gnt_q;
      end
    end
  end

  // Output decode: strobes only in ISSUE, ack only in DONE.
  always_comb begin
    mem_en          = (state_q == StIssue);
    mem_we          = (state_q == StIssue) & we_q;
    f_ack           = (state_q == StDone) && (gnt_q == GNT_FETCH);
    d_ack           = (state_q == StDone) && (gnt_q == GNT_DATA);
    mem_byte_enable = be_q;
    mem_byte_select = bs_q;
    mem_addr        = addr_q;
    mem_wdata       = wdata_q;
    rdata           = rdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered memory.
module tb_mem_arbiter;
  import d16_mem_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic          d_byte = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we, mem_byte_enable, mem_byte_select;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_data_out = '0;
  logic          mem_wait = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .f_req           (f_req),
    .f_addr          (f_addr),
    .f_ack           (f_ack),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_byte          (d_byte),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_ack           (d_ack),
    .rdata           (rdata),
    .mem_en          (mem_en),
    .mem_we          (mem_we),
    .mem_byte_enable (mem_byte_enable),
    .mem_byte_select (mem_byte_select),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_data_out    (mem_data_out),
    .mem_wait        (mem_wait)
  );

  // Behavioural memory: byte_select=1 addresses the high byte, byte reads zero-extend.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (mem_en && !mem_wait) begin
      if (mem_we) begin
        if (mem_byte_enable) begin
          if (mem_byte_select) mem[mem_addr[7:0]][15:8] <= mem_wdata[7:0];
          else                 mem[mem_addr[7:0]][7:0]  <= mem_wdata[7:0];
        end else begin
          mem[mem_addr[7:0]] <= mem_wdata;
        end
      end else if (mem_byte_enable) begin
        mem_data_out <= mem_byte_select ? {8'h00, mem[mem_addr[7:0]][15:8]}
                                        : {8'h00, mem[mem_addr[7:0]][7:0]};
      end else begin
        mem_data_out <= mem[mem_addr[7:0]];
      end
    end
  end

  typedef struct {
    string       name;
    bit          fetch;
    bit          we;
    bit          byt;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          waits;
    logic [15:0] exp_maddr;
    bit          exp_be;
    bit          exp_bs;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];
  vec_t reissue;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f_req = 1'b0;
    d_req = 1'b0;
    mem_wait = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge while the DUT is idle; returns at a negedge while idle.
  task automatic run_access(input vec_t v);
    int c, en_cnt, wait_left;
    bit got;
    c = 0;
    en_cnt = 0;
    wait_left = v.waits;
    got = 1'b0;
    if (v.fetch) begin
      f_req  = 1'b1;
      f_addr = v.addr;
    end else begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_byte  = v.byt;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end
    while (!got && c < 20) begin
      @(negedge clk);
      c++;
      if (mem_en) begin
        en_cnt++;
        check({v.name, " mem_addr"}, 32'(mem_addr), 32'(v.exp_maddr));
        check({v.name, " mem_we"}, 32'(mem_we), 32'(v.we));
        check({v.name, " byte_enable"}, 32'(mem_byte_enable), 32'(v.exp_be));
        check({v.name, " byte_select"}, 32'(mem_byte_select), 32'(v.exp_bs));
        if (v.we) check({v.name, " mem_wdata"}, 32'(mem_wdata), 32'(v.wdata));
      end
      if (mem_en && wait_left > 0) begin
        mem_wait = 1'b1;
        wait_left--;
      end else begin
        mem_wait = 1'b0;
      end
      if (f_ack || d_ack) begin
        got = 1'b1;
        check({v.name, " f_ack"}, 32'(f_ack), 32'(v.fetch));
        check({v.name, " d_ack"}, 32'(d_ack), 32'(!v.fetch));
        check({v.name, " latency"}, 32'(c), 32'(v.exp_lat));
        check({v.name, " en_cycles"}, 32'(en_cnt), 32'(1 + v.waits));
        check({v.name, " rdata"}, 32'(rdata), 32'(v.exp_rdata));
      end
    end
    if (!got) check({v.name, " ack_timeout"}, 32'(0), 32'(1));
    f_req = 1'b0;
    d_req = 1'b0;
    mem_wait = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int c, n_ack, last_c;
    bit expect_fetch;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[2] = 16'h0034;
    mem[3] = 16'hBEEF;
    mem[4] = 16'h1357;

    //          name        f  we b  addr      wdata     w  maddr     be bs rdata     lat
    vecs[0]  = '{"fetch6",  1, 0, 0, 16'h0006, 16'h0000, 0, 16'h0003, 0, 0, 16'hBEEF, 3};
    vecs[1]  = '{"stb5",    0, 1, 1, 16'h0005, 16'h12AB, 0, 16'h0002, 1, 1, 16'hBEEF, 2};
    vecs[2]  = '{"ldw4",    0, 0, 0, 16'h0004, 16'h0000, 0, 16'h0002, 0, 0, 16'hAB34, 3};
    vecs[3]  = '{"ldw9",    0, 0, 0, 16'h0009, 16'h0000, 0, 16'h0004, 0, 0, 16'h1357, 3};
    vecs[4]  = '{"fetchw2", 1, 0, 0, 16'h0006, 16'h0000, 2, 16'h0003, 0, 0, 16'hBEEF, 5};
    vecs[5]  = '{"ldb4",    0, 0, 1, 16'h0004, 16'h0000, 0, 16'h0002, 1, 0, 16'h0034, 3};
    vecs[6]  = '{"ldb5",    0, 0, 1, 16'h0005, 16'h0000, 0, 16'h0002, 1, 1, 16'h00AB, 3};
    vecs[7]  = '{"stw10",   0, 1, 0, 16'h0010, 16'hCAFE, 0, 16'h0008, 0, 0, 16'h00AB, 2};
    vecs[8]  = '{"fetch11", 1, 0, 0, 16'h0011, 16'h0000, 0, 16'h0008, 0, 0, 16'hCAFE, 3};
    vecs[9]  = '{"stww1",   0, 1, 0, 16'h0012, 16'h5A5A, 1, 16'h0009, 0, 0, 16'hCAFE, 3};
    vecs[10] = '{"fetch12", 1, 0, 0, 16'h0012, 16'h0000, 0, 16'h0009, 0, 0, 16'h5A5A, 3};
    reissue  = '{"reissue", 0, 0, 0, 16'h0004, 16'h0000, 0, 16'h0002, 0, 0, 16'hAB34, 3};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst f_ack", 32'(f_ack), 32'(0));
    check("rst d_ack", 32'(d_ack), 32'(0));
    check("rst rdata", 32'(rdata), 32'(0));
    check("rst mem_en", 32'(mem_en), 32'(0));
    check("rst mem_we", 32'(mem_we), 32'(0));
    check("rst mem_addr", 32'(mem_addr), 32'(0));
    check("rst mem_wdata", 32'(mem_wdata), 32'(0));
    check("rst mem_be_bs", 32'({mem_byte_enable, mem_byte_select}), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_access(vecs[i]);

    // Continuous tie from reset: grants alternate fetch, data, fetch, ... with 4-cycle spacing.
    do_reset();
    f_addr  = 16'h0006;
    d_we    = 1'b0;
    d_byte  = 1'b0;
    d_addr  = 16'h0009;
    f_req   = 1'b1;
    d_req   = 1'b1;
    c = 0;
    n_ack = 0;
    last_c = 0;
    expect_fetch = 1'b1;
    while (n_ack < 8 && c < 60) begin
      @(negedge clk);
      c++;
      if (f_ack || d_ack) begin
        check("tie f_ack", 32'(f_ack), 32'(expect_fetch));
        check("tie d_ack", 32'(d_ack), 32'(!expect_fetch));
        check("tie rdata", 32'(rdata), expect_fetch ? 32'h0000BEEF : 32'h00001357);
        check("tie spacing", 32'(c - last_c), (n_ack == 0) ? 32'(3) : 32'(4));
        last_c = c;
        n_ack++;
        expect_fetch = !expect_fetch;
      end
    end
    check("tie ack_count", 32'(n_ack), 32'(8));
    f_req = 1'b0;
    d_req = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during RESP of a load: no ack, rdata cleared, strobes low.
    d_we   = 1'b0;
    d_byte = 1'b0;
    d_addr = 16'h0004;
    d_req  = 1'b1;
    repeat (2) @(negedge clk);
    check("rsp_rst pre mem_en", 32'(mem_en), 32'(0));
    check("rsp_rst pre d_ack", 32'(d_ack), 32'(0));
    rst_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check("rsp_rst d_ack", 32'(d_ack), 32'(0));
    check("rsp_rst rdata", 32'(rdata), 32'(0));
    check("rsp_rst mem_en", 32'(mem_en), 32'(0));
    check("rsp_rst mem_addr", 32'(mem_addr), 32'(0));
    rst_n = 1'b1;
    run_access(reissue);

    // Reset during ISSUE: mem_en low on the following cycle.
    d_addr = 16'h0006;
    d_req  = 1'b1;
    @(negedge clk);
    check("iss_rst pre mem_en", 32'(mem_en), 32'(1));
    rst_n = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check("iss_rst mem_en", 32'(mem_en), 32'(0));
    check("iss_rst d_ack", 32'(d_ack), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
